wah_svf: RTL

Resonant band-pass stage of the wah effect, directly downstream of the cutoff frequency unit. It consumes the conditioned audio sample and the per-sample cutoff coefficient, and runs one Chamberlin state-variable filter iteration per sample strobe. One multiplier is time-shared across a small FSM. The band-pass result drives the effect's `filter_out`.

---
 rtl/wah_svf.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/wah_svf.sv
// wah_svf: resonant band-pass stage of the wah effect.
// One Chamberlin state-variable filter iteration per sample strobe, with a
// single multiplier time-shared across a five-state FSM.
// Optional feature macro: WAH_SVF_SATURATE_EN selects clamping saturation.
// Without it, results are truncated to the destination width and wrap.
module wah_svf #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int FREQ_FRAC    = 16,
  parameter int DAMP_FRAC    = 14
) (
  input  logic                    system_clock,
  input  logic                    rst,
  input  logic                    sample_strobe,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic [SAMPLE_WIDTH-1:0] cutoff_freq,
  input  logic [15:0]             damping,
  output logic [SAMPLE_WIDTH-1:0] filter_out,
  output logic                    out_valid,
  output logic                    busy,
  output logic                    overrun
);

  // Internal state width carries two guard bits above the sample width.
  localparam int IW = SAMPLE_WIDTH + 2;
  // Coefficient operand: widest of clamped F and D, plus a zero sign bit.
  localparam int FW = FREQ_FRAC + 1;
  localparam int CW = ((FW > 16) ? FW : 16) + 1;
  localparam int PW = CW + IW;
  localparam int SW = PW + 2;
  localparam logic [SAMPLE_WIDTH-1:0] F_ONE = SAMPLE_WIDTH'(1) << FREQ_FRAC;

`ifdef WAH_SVF_SATURATE_EN
  localparam logic signed [SW-1:0] IW_MAX  = {{(SW-IW+1){1'b0}}, {(IW-1){1'b1}}};
  localparam logic signed [SW-1:0] IW_MIN  = ~IW_MAX;
  localparam logic signed [IW-1:0] OUT_MAX = {3'b000, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic signed [IW-1:0] OUT_MIN = ~OUT_MAX;
`endif

  typedef enum logic [2:0] {IDLE, S_LOW, S_HIGH, S_BAND, S_OUT} state_t;

  state_t               state;
  logic signed [IW-1:0] low;
  logic signed [IW-1:0] band;
  logic signed [IW-1:0] high;
  logic signed [IW-1:0] x_reg;
  logic [CW-1:0]        f_reg;
  logic [CW-1:0]        d_reg;

  logic signed [CW-1:0] mul_a;
  logic signed [IW-1:0] mul_b;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] term;
  logic signed [SW-1:0] acc;
  logic signed [IW-1:0] alu_res;

  // Full-width sum reduced to the internal state width.
  function automatic logic signed [IW-1:0] sat_int(input logic signed [SW-1:0] v);
`ifdef WAH_SVF_SATURATE_EN
    if (v > IW_MAX)      return IW'(IW_MAX);
    else if (v < IW_MIN) return IW'(IW_MIN);
    else                 return IW'(v);
`else
    return IW'(v);
`endif
  endfunction

  // Internal band value reduced to the output sample width.
  function automatic logic [SAMPLE_WIDTH-1:0] sat_out(input logic signed [IW-1:0] v);
`ifdef WAH_SVF_SATURATE_EN
    if (v > OUT_MAX)      return SAMPLE_WIDTH'(OUT_MAX);
    else if (v < OUT_MIN) return SAMPLE_WIDTH'(OUT_MIN);
    else                  return SAMPLE_WIDTH'(v);
`else
    return SAMPLE_WIDTH'(v);
`endif
  endfunction

  // Shared multiplier operand select: D only in S_HIGH, high only in S_BAND.
  always_comb begin
    mul_a = $signed(f_reg);
    mul_b = band;
    if (state == S_HIGH) mul_a = $signed(d_reg);
    if (state == S_BAND) mul_b = high;
  end

  assign prod = PW'(mul_a) * PW'(mul_b);

  // Scaled product and the per-state full-width accumulation.
  always_comb begin
    term = (state == S_HIGH) ? (prod >>> DAMP_FRAC) : (prod >>> FREQ_FRAC);
    case (state)
      S_HIGH:  acc = SW'(x_reg) - SW'(low) - SW'(term);
      S_BAND:  acc = SW'(band) + SW'(term);
      default: acc = SW'(low) + SW'(term);
    endcase
  end

  assign alu_res = sat_int(acc);

  // Sequencer: capture, three filter steps, output; registered status flags.
  always_ff @(posedge system_clock or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      low        <= '0;
      band       <= '0;
      high       <= '0;
      x_reg      <= '0;
      f_reg      <= '0;
      d_reg      <= '0;
      filter_out <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (sample_strobe && (state != IDLE)) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (sample_strobe) begin
            x_reg <= IW'($signed(sample_in));
            f_reg <= (cutoff_freq > F_ONE) ? CW'(F_ONE) : CW'(cutoff_freq);
            d_reg <= CW'(damping);
            busy  <= 1'b1;
            state <= S_LOW;
          end
        end
        S_LOW: begin
          low   <= alu_res;
          state <= S_HIGH;
        end
        S_HIGH: begin
          high  <= alu_res;
          state <= S_BAND;
        end
        S_BAND: begin
          band  <= alu_res;
          state <= S_OUT;
        end
        S_OUT: begin
          filter_out <= sat_out(band);
          out_valid  <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
